// File: rtl/mem_arbiter.sv
// Two-client arbiter for one async-read / sync-write memory, with independent
// round-robin read and write ports. Optional macro: MEM_ARB_RAW_BYPASS_EN (RAW forwarding).
module mem_arbiter #(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c0_req,
  input  logic                c1_req,
  input  logic                c0_we,
  input  logic                c1_we,
  input  logic [DEPTH-1:0]    c0_addr,
  input  logic [DEPTH-1:0]    c1_addr,
  input  logic [BIT_SIZE-1:0] c0_wdata,
  input  logic [BIT_SIZE-1:0] c1_wdata,
  output logic                c0_gnt,
  output logic                c1_gnt,
  output logic                c0_rvalid,
  output logic                c1_rvalid,
  output logic [BIT_SIZE-1:0] c0_rdata,
  output logic [BIT_SIZE-1:0] c1_rdata,
  output logic                mem_write_enable,
  output logic [DEPTH-1:0]    mem_write_addr,
  output logic [DEPTH-1:0]    mem_read_addr,
  output logic [BIT_SIZE-1:0] mem_data_in,
  input  logic [BIT_SIZE-1:0] mem_data_out
);

  typedef enum logic {CLIENT0 = 1'b0, CLIENT1 = 1'b1} client_e;

  client_e             rd_ptr_q, rd_ptr_d;
  client_e             wr_ptr_q, wr_ptr_d;
  logic                c0_rvalid_q, c1_rvalid_q;
  logic [BIT_SIZE-1:0] c0_rdata_q, c0_rdata_d;
  logic [BIT_SIZE-1:0] c1_rdata_q, c1_rdata_d;
  logic [DEPTH-1:0]    rd_addr_q, rd_addr_d;

  logic                c0_rd, c1_rd, c0_wr, c1_wr;
  logic                c0_rd_gnt, c1_rd_gnt, c0_wr_gnt, c1_wr_gnt;
  logic                rd_gnt;
  logic [BIT_SIZE-1:0] rd_data;

  // Reset is folded into the request qualifiers so grants and the write strobe
  // are forced low while rst_n is asserted, independent of the clock.
  always_comb begin
    c0_rd = rst_n & c0_req & ~c0_we;
    c1_rd = rst_n & c1_req & ~c1_we;
    c0_wr = rst_n & c0_req &  c0_we;
    c1_wr = rst_n & c1_req &  c1_we;

    c0_rd_gnt = c0_rd & (~c1_rd | (rd_ptr_q == CLIENT0));
    c1_rd_gnt = c1_rd & (~c0_rd | (rd_ptr_q == CLIENT1));
    c0_wr_gnt = c0_wr & (~c1_wr | (wr_ptr_q == CLIENT0));
    c1_wr_gnt = c1_wr & (~c0_wr | (wr_ptr_q == CLIENT1));
  end

  assign c0_gnt = c0_rd_gnt | c0_wr_gnt;
  assign c1_gnt = c1_rd_gnt | c1_wr_gnt;
  assign rd_gnt = c0_rd_gnt | c1_rd_gnt;

  assign mem_write_enable = c0_wr_gnt | c1_wr_gnt;
  assign mem_write_addr   = c1_wr_gnt ? c1_addr  : c0_addr;
  assign mem_data_in      = c1_wr_gnt ? c1_wdata : c0_wdata;

  // The async-read memory needs the address during the grant cycle, so the
  // winner's address is passed straight through and only held when idle.
  assign rd_addr_d     = c1_rd_gnt ? c1_addr : c0_addr;
  assign mem_read_addr = rd_gnt ? rd_addr_d : rd_addr_q;

`ifdef MEM_ARB_RAW_BYPASS_EN
  assign rd_data = (mem_write_enable && (mem_write_addr == rd_addr_d)) ? mem_data_in
                                                                       : mem_data_out;
`else
  assign rd_data = mem_data_out;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    c0_rdata_d = c0_rdata_q;
    c1_rdata_d = c1_rdata_q;
    if (c0_rd && c1_rd) rd_ptr_d = (rd_ptr_q == CLIENT0) ? CLIENT1 : CLIENT0;
    if (c0_wr && c1_wr) wr_ptr_d = (wr_ptr_q == CLIENT0) ? CLIENT1 : CLIENT0;
    if (c0_rd_gnt)      c0_rdata_d = rd_data;
    if (c1_rd_gnt)      c1_rdata_d = rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= CLIENT0;
      wr_ptr_q    <= CLIENT0;
      c0_rvalid_q <= 1'b0;
      c1_rvalid_q <= 1'b0;
      c0_rdata_q  <= '0;
      c1_rdata_q  <= '0;
      rd_addr_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      c0_rvalid_q <= c0_rd_gnt;
      c1_rvalid_q <= c1_rd_gnt;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      if (rd_gnt) rd_addr_q <= rd_addr_d;
    end
  end

  assign c0_rvalid = c0_rvalid_q;
  assign c1_rvalid = c1_rvalid_q;
  assign c0_rdata  = c0_rdata_q;
  assign c1_rdata  = c1_rdata_q;

endmodule
